button_debouncer: RTL and testbench
===================================

# button_debouncer

Front-end conditioning stage for the board push buttons. It takes the raw active-low pad signals, synchronizes them into the `clock` domain and debounces each one independently. It drives clean active-high levels plus one-cycle press/release pulses to the LED decode logic. It sits between the button pads and the combinational case-decode that selects the red/green/blue LED.

## Interface
Parameters:
- `NUM_BUTTONS`, default 2: number of independent button channels.
- `SYNC_STAGES`, default 2: synchronizer flop depth per channel. Legal range is at least 2.
- `DEBOUNCE_CYCLES`, default 250000: consecutive identical synchronized samples required to accept a change. Legal range is at least 2.
- `COUNT_WIDTH`, derived localparam: `$clog2(DEBOUNCE_CYCLES)`. Not overridable.

Ports (one clock; reset is synchronous and active-high):
- `clock` in, 1: sole clock. All flops are rising-edge.
- `reset` in, 1: synchronous, active-high. Sampled on `clock`.
- `push_button_n` in, NUM_BUTTONS: raw pad inputs, active-low, asynchronous.
- `push_button` out, NUM_BUTTONS: debounced level, active-high (1 = pressed). Registered.
- `pressed` out, NUM_BUTTONS: one-cycle pulse on an accepted press. Registered.
- `released` out, NUM_BUTTONS: one-cycle pulse on an accepted release. Registered.

## Operation
Per channel i, fully independent:
- The raw input is inverted, then passed through SYNC_STAGES flops. The last flop is `sync[i]`, where 1 = pressed.
- A 4-state FSM and a COUNT_WIDTH counter track the channel:
  - IDLE (released):
    - sync=1: go to PRESS_WAIT with count=1.
    - otherwise: stay.
  - PRESS_WAIT:
    - sync=0: go to IDLE with count=0. This discards the glitch and produces no output change.
    - sync=1 and count==DEBOUNCE_CYCLES-1: go to PRESSED. Set `push_button[i]`=1 and pulse `pressed[i]`.
    - otherwise: count+1.
  - PRESSED:
    - sync=0: go to RELEASE_WAIT with count=1.
    - otherwise: stay.
  - RELEASE_WAIT:
    - sync=1: go to PRESSED with count=0. No output change.
    - sync=0 and count==DEBOUNCE_CYCLES-1: go to IDLE. Set `push_button[i]`=0 and pulse `released[i]`.
    - otherwise: count+1.
- `pressed[i]` and `released[i]` are high for exactly one cycle and are never both high.
- The counter never wraps. Its maximum value is DEBOUNCE_CYCLES-1, and it is cleared on every state change.
- Simultaneous events on different channels are handled independently. Both channels may pulse in the same cycle.
- A bounce that reverts inside the window restarts counting from scratch on the next change.

## Timing
- Reset values:
  - all outputs are 0;
  - the FSM is in IDLE;
  - count is 0;
  - all synchronizer flops are at the "released" value (sync=0).
- Reset has priority over all other logic. A reset asserted mid-window aborts the window with no pulse. If the button is still held after reset deasserts, the press is re-accepted after the full latency.
- While reset is held, outputs stay 0 regardless of the inputs.
- Press latency:
  - A raw level present before sampling edge 1, and held stable, makes `push_button[i]` and `pressed[i]` go high after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - `pressed[i]` falls after the next edge.
- Release latency is identical.
- Minimum accepted pulse width at the pad is DEBOUNCE_CYCLES cycles.

## Structure
- Shared package `sample_pkg`:
  - FSM state encodings: IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3;
  - the default DEBOUNCE_CYCLES constant.
- Sub-module `button_debounce_channel`: one synchronizer, FSM and counter. It is instantiated NUM_BUTTONS times via generate.
- The top level is only the generate loop and the port slicing.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8, SYNC_STAGES=2 and NUM_BUTTONS=2.
1. Reset with `push_button_n`=2'b00 held throughout reset → all outputs 0 while reset is asserted. After reset deasserts, `push_button`=2'b11 following 10 edges, with a single `pressed`=2'b11 pulse.
2. Clean press: drive `push_button_n[0]` low before edge 1 and hold → `push_button[0]` goes to 1 after edge 10, `pressed[0]` is high for exactly one cycle, and channel 1 is unchanged.
3. Bounce: drive `push_button_n[0]` low for 5 cycles, high for 3, then low held → no output until 10 edges after the final fall, then a single `pressed[0]` pulse.
4. Release with glitch: from PRESSED, release for 7 cycles, press for 1, then release held → `push_button[0]` stays 1 until 10 edges after the final release, then a single `released[0]` pulse.
5. Reset mid-window: assert reset at count=5 of PRESS_WAIT with the button held → no `pressed` pulse. After reset deasserts, press is accepted after the full 10-edge latency.
6. Simultaneous: both buttons pressed on the same edge → `pressed`=2'b11 in the same cycle. Releasing only button 1 afterwards → `released`=2'b10 and `push_button`=2'b01.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared types and defaults for the push-button conditioning stage.
package sample_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: pad synchronizer, debounce FSM and stability counter.
module button_debounce_channel
    import sample_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic level,
    output logic pressed,
    output logic released
);

    localparam int unsigned COUNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    debounce_state_e        state;
    debounce_state_e        state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   level_next;
    logic                   pressed_next;
    logic                   released_next;

    // Invert the active-low pad, then shift through the synchronizer chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ~button_n};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            level    <= level_next;
            pressed  <= pressed_next;
            released <= released_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (sync) begin
                    state_next = PRESS_WAIT;
                    count_next = COUNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count == COUNT_LAST) begin
                    state_next = PRESSED;
                    count_next = '0;
                end else begin
                    count_next = count + COUNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_next = RELEASE_WAIT;
                    count_next = COUNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_next = PRESSED;
                    count_next = '0;
                end else if (count == COUNT_LAST) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count + COUNT_ONE;
                end
            end
        endcase
    end

    // Level and pulses change only when a waiting window completes.
    always_comb begin
        level_next    = level;
        pressed_next  = 1'b0;
        released_next = 1'b0;
        if (state == PRESS_WAIT && sync && count == COUNT_LAST) begin
            level_next   = 1'b1;
            pressed_next = 1'b1;
        end
        if (state == RELEASE_WAIT && !sync && count == COUNT_LAST) begin
            level_next    = 1'b0;
            released_next = 1'b1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BUTTONS active-low pads into clean levels and press/release pulses.
module button_debouncer
    import sample_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS     = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] push_button_n,
    output logic [NUM_BUTTONS-1:0] push_button,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] released
);

    for (genvar i = 0; i < int'(NUM_BUTTONS); i++) begin : g_channel
        button_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clock    (clock),
            .reset    (reset),
            .button_n (push_button_n[i]),
            .level    (push_button[i]),
            .pressed  (pressed[i]),
            .released (released[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with an 8-cycle window and 2-flop synchronizer.
module tb_button_debouncer;

    logic       clock;
    logic       reset;
    logic [1:0] push_button_n;
    logic [1:0] push_button;
    logic [1:0] pressed;
    logic [1:0] released;

    int errors = 0;
    int checks = 0;

    button_debouncer #(
        .NUM_BUTTONS     (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .push_button_n (push_button_n),
        .push_button   (push_button),
        .pressed       (pressed),
        .released      (released)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed vector is {push_button, pressed, released}.
    function automatic logic [5:0] obs();
        return {push_button, pressed, released};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge before sampling/driving.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_hold(input string tag, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, obs(), exp);
        end
    endtask

    task automatic run_edge(input string tag, input logic [5:0] exp);
        step();
        check(tag, obs(), exp);
    endtask

    initial begin
        reset         = 1'b1;
        push_button_n = 2'b00;

        // Reset held with both buttons down: everything stays quiet.
        run_hold("reset_hold", 4, 6'b00_00_00);
        reset = 1'b0;
        run_hold("post_reset_wait", 9, 6'b00_00_00);
        run_edge("post_reset_accept", 6'b11_11_00);
        run_edge("post_reset_pulse_end", 6'b11_00_00);

        push_button_n = 2'b11;
        run_hold("release_both_wait", 9, 6'b11_00_00);
        run_edge("release_both", 6'b00_00_11);
        run_edge("release_both_end", 6'b00_00_00);

        // Clean press on channel 0.
        push_button_n = 2'b10;
        run_hold("clean_wait", 9, 6'b00_00_00);
        run_edge("clean_accept", 6'b01_01_00);
        run_edge("clean_pulse_end", 6'b01_00_00);

        push_button_n = 2'b11;
        run_hold("clean_rel_wait", 9, 6'b01_00_00);
        run_edge("clean_rel", 6'b00_00_01);
        run_edge("clean_rel_end", 6'b00_00_00);

        // Bounce: 5 low, 3 high, then low held.
        push_button_n = 2'b10;
        run_hold("bounce_low", 5, 6'b00_00_00);
        push_button_n = 2'b11;
        run_hold("bounce_high", 3, 6'b00_00_00);
        push_button_n = 2'b10;
        run_hold("bounce_wait", 9, 6'b00_00_00);
        run_edge("bounce_accept", 6'b01_01_00);
        run_edge("bounce_pulse_end", 6'b01_00_00);

        // Release glitch: 7 released, 1 pressed, then released held.
        push_button_n = 2'b11;
        run_hold("rglitch_rel", 7, 6'b01_00_00);
        push_button_n = 2'b10;
        run_hold("rglitch_press", 1, 6'b01_00_00);
        push_button_n = 2'b11;
        run_hold("rglitch_wait", 9, 6'b01_00_00);
        run_edge("rglitch_accept", 6'b00_00_01);
        run_edge("rglitch_pulse_end", 6'b00_00_00);

        // Reset while PRESS_WAIT has counted to 5.
        push_button_n = 2'b10;
        run_hold("midrst_window", 7, 6'b00_00_00);
        reset = 1'b1;
        run_hold("midrst_hold", 3, 6'b00_00_00);
        reset = 1'b0;
        run_hold("midrst_wait", 9, 6'b00_00_00);
        run_edge("midrst_accept", 6'b01_01_00);
        run_edge("midrst_pulse_end", 6'b01_00_00);

        push_button_n = 2'b11;
        run_hold("midrst_rel_wait", 9, 6'b01_00_00);
        run_edge("midrst_rel", 6'b00_00_01);
        run_edge("midrst_rel_end", 6'b00_00_00);

        // Simultaneous press, then release only button 1.
        push_button_n = 2'b00;
        run_hold("simul_wait", 9, 6'b00_00_00);
        run_edge("simul_accept", 6'b11_11_00);
        run_edge("simul_pulse_end", 6'b11_00_00);
        push_button_n = 2'b10;
        run_hold("simul_rel1_wait", 9, 6'b11_00_00);
        run_edge("simul_rel1", 6'b01_00_10);
        run_edge("simul_rel1_end", 6'b01_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
